// File: rtl/lot_gate_arb.sv
// Gate arbiter/sequencer: grants one parking-lot gate at a time and owns the occupancy count pp.
// Build option LOT_GATE_RR_EN: round-robin between the two entry gates (default build is fixed priority, gate 0 first).
//
// state  | meaning
// S_IDLE | no gate open; pick exit first, then an entry, as eligibility allows
// S_OPEN | one gate open; cnt counts down the remaining open cycles
module lot_gate_arb #(
   parameter int GATE_CYCLES = 4,
   parameter int CAP         = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] ent_req,
   input  logic       ext_req,
   output logic [1:0] ent_ack,
   output logic       ext_ack,
   output logic [2:0] gate_open,
   output logic [2:0] pp,
   output logic       full,
   output logic       empty,
   output logic       busy
);

   typedef enum logic {S_IDLE, S_OPEN} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(GATE_CYCLES - 1);
   localparam logic [2:0] PP_CAP   = 3'(CAP);

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic [2:0] pp_nx;
   logic [2:0] gate_nx;
   logic [1:0] ent_ack_nx;
   logic       ext_ack_nx;
   logic       ext_ok;
   logic [1:0] ent_ok;
   logic [1:0] ent_pick;

   assign full   = (pp == PP_CAP);
   assign empty  = (pp == 3'd0);
   assign busy   = (state != S_IDLE);
   assign ext_ok = ext_req & ~empty;
   assign ent_ok = ent_req & {2{~full}};

`ifdef LOT_GATE_RR_EN
   logic rr_last;
   logic rr_nx;

   // On contention the gate that did not win last time goes next.
   always_comb begin
      ent_pick = ent_ok;
      if (ent_ok == 2'b11) begin
         ent_pick = rr_last ? 2'b01 : 2'b10;
      end
   end
`else
   always_comb begin
      ent_pick = 2'b00;
      if (ent_ok[0]) begin
         ent_pick = 2'b01;
      end else if (ent_ok[1]) begin
         ent_pick = 2'b10;
      end
   end
`endif

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      pp_nx      = pp;
      gate_nx    = gate_open;
      ent_ack_nx = 2'b00;
      ext_ack_nx = 1'b0;
`ifdef LOT_GATE_RR_EN
      rr_nx      = rr_last;
`endif
      case (state)
         S_IDLE: begin
            if (ext_ok) begin
               ext_ack_nx = 1'b1;
               gate_nx    = 3'b100;
               cnt_nx     = CNT_LOAD;
               pp_nx      = pp - 3'd1;
               state_nx   = S_OPEN;
            end else if (ent_pick != 2'b00) begin
               ent_ack_nx = ent_pick;
               gate_nx    = {1'b0, ent_pick};
               cnt_nx     = CNT_LOAD;
               pp_nx      = pp + 3'd1;
               state_nx   = S_OPEN;
`ifdef LOT_GATE_RR_EN
               rr_nx      = ent_pick[1];
`endif
            end
         end
         S_OPEN: begin
            if (cnt == 4'd0) begin
               gate_nx  = 3'b000;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         pp        <= 3'd0;
         gate_open <= 3'b000;
         ent_ack   <= 2'b00;
         ext_ack   <= 1'b0;
`ifdef LOT_GATE_RR_EN
         rr_last   <= 1'b1;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pp        <= pp_nx;
         gate_open <= gate_nx;
         ent_ack   <= ent_ack_nx;
         ext_ack   <= ext_ack_nx;
`ifdef LOT_GATE_RR_EN
         rr_last   <= rr_nx;
`endif
      end
   end

endmodule

// File: tb/tb_lot_gate_arb.sv
// Scoreboard bench for lot_gate_arb: stimulus pushes expected grants, a negedge monitor pops and compares them.
module tb_lot_gate_arb;

   localparam int G   = 4;
   localparam int CAP = 7;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] ent_req = 2'b00;
   logic       ext_req = 1'b0;
   logic [1:0] ent_ack;
   logic       ext_ack;
   logic [2:0] gate_open;
   logic [2:0] pp;
   logic       full;
   logic       empty;
   logic       busy;

   lot_gate_arb #(.GATE_CYCLES(G), .CAP(CAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .ent_req   (ent_req),
      .ext_req   (ext_req),
      .ent_ack   (ent_ack),
      .ext_ack   (ext_ack),
      .gate_open (gate_open),
      .pp        (pp),
      .full      (full),
      .empty     (empty),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ack;   // {exit, ent1, ent0}
      int         pp;    // occupancy visible in the ack cycle
      int         gap;   // cycles since previous ack, 0 = don't care
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_ack_cyc = 0;
   int   open_cnt = 0;
   bit   width_en = 1'b1;
   logic [2:0] prev_ack = 3'b000;
   logic [2:0] ack_v;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push(input logic [2:0] ack, input int ppv, input int gap);
      exp_t x;
      x.ack = ack;
      x.pp  = ppv;
      x.gap = gap;
      exp_q.push_back(x);
   endtask

   // Monitor: every ack the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      ack_v = {ext_ack, ent_ack};
      if (ack_v != 3'b000) begin
         chk("ack_width", int'(prev_ack), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", int'(ack_v), 0);
         end else begin
            e = exp_q.pop_front();
            chk("ack_vec", int'(ack_v), int'(e.ack));
            chk("gate_open_at_ack", int'(gate_open), int'(e.ack));
            chk("pp_at_ack", int'(pp), e.pp);
            if (e.gap != 0) chk("grant_gap", cyc - last_ack_cyc, e.gap);
         end
         last_ack_cyc = cyc;
      end
      prev_ack = ack_v;
      if (gate_open != 3'b000) begin
         open_cnt++;
      end else if (open_cnt != 0) begin
         if (width_en) chk("open_width", open_cnt, G);
         open_cnt = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run until every expected grant has been seen and the FSM is idle.
   task automatic drain(input int max_cyc, input bit auto_drop);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         step();
         if (auto_drop) begin
            if (ent_ack[0]) ent_req[0] = 1'b0;
            if (ent_ack[1]) ent_req[1] = 1'b0;
            if (ext_ack)    ext_req    = 1'b0;
         end
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      if (!done) chk("drain_timeout_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      ent_req = 2'b00;
      ext_req = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic grant_entry(input int gate, input int pp_after);
      push(gate == 0 ? 3'b001 : 3'b010, pp_after, 0);
      ent_req[gate] = 1'b1;
      drain(20, 1'b1);
   endtask

   initial begin
      // Reset with every request high
      reset   = 1'b0;
      ent_req = 2'b11;
      ext_req = 1'b1;
      step();
      step();
      chk("rst_pp", int'(pp), 0);
      chk("rst_gate_open", int'(gate_open), 0);
      chk("rst_acks", int'({ext_ack, ent_ack}), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_busy", int'(busy), 0);
      push(3'b001, 1, 0);
      ent_req = 2'b01;
      ext_req = 1'b0;
      reset   = 1'b1;
      drain(20, 1'b1);
      chk("first_pp", int'(pp), 1);

      // Fill to capacity, then a held entry waits for an exit
      for (int k = 2; k <= CAP; k++) grant_entry(0, k);
      chk("cap_full", int'(full), 1);
      ent_req = 2'b01;
      for (int i = 0; i < 10; i++) step();
      chk("held_pp", int'(pp), 7);
      chk("held_busy", int'(busy), 0);
      chk("held_full", int'(full), 1);
      push(3'b100, 6, 0);
      push(3'b001, 7, G + 1);
      ext_req = 1'b1;
      drain(40, 1'b1);
      chk("refill_pp", int'(pp), 7);

      // Exit request on an empty lot is ignored
      do_reset();
      ext_req = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("empty_exit_pp", int'(pp), 0);
      chk("empty_exit_busy", int'(busy), 0);
      chk("empty_exit_empty", int'(empty), 1);
      ext_req = 1'b0;

      // Both entries held continuously
`ifdef LOT_GATE_RR_EN
      push(3'b001, 1, 0);
      push(3'b010, 2, G + 1);
      push(3'b001, 3, G + 1);
      push(3'b010, 4, G + 1);
`else
      push(3'b001, 1, 0);
      push(3'b001, 2, G + 1);
      push(3'b001, 3, G + 1);
      push(3'b001, 4, G + 1);
`endif
      ent_req = 2'b11;
      drain(60, 1'b0);
      ent_req = 2'b00;
      chk("contention_pp", int'(pp), 4);

      // Exit beats both entries at pp=3
      do_reset();
      grant_entry(1, 1);
      grant_entry(1, 2);
      grant_entry(1, 3);
      push(3'b100, 2, 0);
      push(3'b001, 3, G + 1);
      push(3'b010, 4, G + 1);
      ent_req = 2'b11;
      ext_req = 1'b1;
      drain(60, 1'b1);
      chk("prio_pp", int'(pp), 4);

      // Reset in cycle 2 of an open period
      width_en = 1'b0;
      push(3'b001, 5, 0);
      ent_req = 2'b01;
      step();
      ent_req = 2'b00;
      step();
      reset = 1'b0;
      step();
      chk("midrst_gate_open", int'(gate_open), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pp", int'(pp), 0);
      chk("midrst_acks", int'({ext_ack, ent_ack}), 0);
      reset = 1'b1;
      step();
      step();
      chk("midrst_idle_pp", int'(pp), 0);
      width_en = 1'b1;

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
